// File: rtl/id_stage_hs_if.sv
// Handshake bundle around the decode stage: IF->ID request side and ID->EX pipeline-register side.
// The decode stage connects through the slave modport; the surrounding pipeline uses master.
interface id_stage_hs_if #(
    parameter int INSTR_WIDTH = 32,
    parameter int PC_WIDTH    = 32,
    parameter int GPR_WIDTH   = 32,
    parameter int CTRL_WIDTH  = 20
);
    logic                   in_valid;
    logic                   in_ready;
    logic [INSTR_WIDTH-1:0] in_instr;
    logic [PC_WIDTH-1:0]    in_pc;

    logic                   out_valid;
    logic                   out_ready;
    logic [CTRL_WIDTH-1:0]  out_ctrl;
    logic [4:0]             out_rd;
    logic [4:0]             out_rs;
    logic [4:0]             out_rt;
    logic [GPR_WIDTH-1:0]   out_imm;
    logic [PC_WIDTH-1:0]    out_next_pc;
    logic [GPR_WIDTH-1:0]   out_data_rs;
    logic [GPR_WIDTH-1:0]   out_data_rt;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_ctrl, out_rd, out_rs, out_rt,
               out_imm, out_next_pc, out_data_rs, out_data_rt
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_ctrl, out_rd, out_rs, out_rt,
               out_imm, out_next_pc, out_data_rs, out_data_rt
    );
endinterface

// File: rtl/id_stage_hs.sv
// Instruction-decode stage: decode register D feeding an EX-facing register E, with stall bubbles,
// backpressure hold, flush and optional squashing of the instruction in a jump's shadow.
module id_stage_hs #(
    parameter int INSTR_WIDTH    = 32,
    parameter int PC_WIDTH       = 32,
    parameter int GPR_WIDTH      = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int REGFILE_SIZE   = 16,
    parameter int CTRL_WIDTH     = 20,
    parameter int DELAY_SLOT     = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    id_stage_hs_if.slave              bus,
    output logic [REG_ADDR_WIDTH-1:0] rs,
    output logic [REG_ADDR_WIDTH-1:0] rt,
    input  logic [GPR_WIDTH-1:0]      data_rs,
    input  logic [GPR_WIDTH-1:0]      data_rt,
    output logic [5:0]                opcode,
    output logic [5:0]                funct,
    input  logic [CTRL_WIDTH-1:0]     ctrl_word,
    input  logic                      is_jump,
    input  logic                      sel_j_jr,
    input  logic                      imm_zext,
    input  logic                      stall_pipeline,
    input  logic                      flush,
    output logic                      jump_valid,
    output logic [PC_WIDTH-1:0]       jump_addr
);

    localparam logic [REG_ADDR_WIDTH-1:0] LAST_REG = REG_ADDR_WIDTH'(REGFILE_SIZE - 1);
    localparam logic [PC_WIDTH-1:0]       PC_ONE   = {{(PC_WIDTH-1){1'b0}}, 1'b1};

    // Fields beyond the implemented register file alias onto the last register.
    function automatic logic [REG_ADDR_WIDTH-1:0] clamp_addr(input logic [4:0] field);
        logic [REG_ADDR_WIDTH-1:0] res;
        if (32'(field) < 32'(REGFILE_SIZE)) begin
            res = REG_ADDR_WIDTH'(field);
        end else begin
            res = LAST_REG;
        end
        return res;
    endfunction

    logic                   r_d_valid;
    logic [INSTR_WIDTH-1:0] r_d_instr;
    logic [PC_WIDTH-1:0]    r_d_pc;
    logic                   r_squash;

    logic                   r_out_valid;
    logic [CTRL_WIDTH-1:0]  r_out_ctrl;
    logic [4:0]             r_out_rd;
    logic [4:0]             r_out_rs;
    logic [4:0]             r_out_rt;
    logic [GPR_WIDTH-1:0]   r_out_imm;
    logic [PC_WIDTH-1:0]    r_out_next_pc;
    logic [GPR_WIDTH-1:0]   r_out_data_rs;
    logic [GPR_WIDTH-1:0]   r_out_data_rt;

    logic                   w_e_free;
    logic                   w_adv;
    logic                   w_bubble;
    logic                   w_in_ready;
    logic                   w_load;
    logic                   w_jump;
    logic                   w_squash_now;
    logic [15:0]            w_imm_raw;
    logic [GPR_WIDTH-1:0]   w_imm;
    logic [PC_WIDTH-1:0]    w_next_pc;
    logic [PC_WIDTH-1:0]    w_jump_addr;

    // Handshake, hazard and datapath decode for the instruction currently in D.
    always_comb begin
        w_e_free   = ~r_out_valid | bus.out_ready;
        w_adv      = r_d_valid & ~stall_pipeline & w_e_free;
        w_bubble   = r_d_valid & stall_pipeline & w_e_free;
        w_in_ready = rst | ~r_d_valid | w_adv;
        w_load     = bus.in_valid & w_in_ready;
        w_jump     = ~rst & w_adv & is_jump;

        // A load coinciding with the jump's advance is already the shadow instruction.
        if (DELAY_SLOT == 0) begin
            w_squash_now = r_squash | w_jump;
        end else begin
            w_squash_now = 1'b0;
        end

        w_imm_raw = r_d_instr[15:0];
        if (imm_zext) begin
            w_imm = {{(GPR_WIDTH-16){1'b0}}, w_imm_raw};
        end else begin
            w_imm = {{(GPR_WIDTH-16){w_imm_raw[15]}}, w_imm_raw};
        end

        w_next_pc = r_d_pc + PC_ONE;

        if (sel_j_jr) begin
            w_jump_addr = PC_WIDTH'(r_d_instr[25:0]);
        end else begin
            w_jump_addr = data_rs[PC_WIDTH-1:0];
        end
    end

    // Decode register, shadow-squash flag and EX pipeline register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_d_valid     <= 1'b0;
            r_d_instr     <= '0;
            r_d_pc        <= '0;
            r_squash      <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_ctrl    <= '0;
            r_out_rd      <= 5'd0;
            r_out_rs      <= 5'd0;
            r_out_rt      <= 5'd0;
            r_out_imm     <= '0;
            r_out_next_pc <= '0;
            r_out_data_rs <= '0;
            r_out_data_rt <= '0;
        end else if (flush) begin
            r_d_valid   <= 1'b0;
            r_squash    <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_ctrl  <= '0;
        end else begin
            if (w_load) begin
                r_squash <= 1'b0;
                if (w_squash_now) begin
                    r_d_valid <= 1'b0;
                end else begin
                    r_d_valid <= 1'b1;
                    r_d_instr <= bus.in_instr;
                    r_d_pc    <= bus.in_pc;
                end
            end else begin
                r_squash <= w_squash_now;
                if (w_adv) begin
                    r_d_valid <= 1'b0;
                end else begin
                    r_d_valid <= r_d_valid;
                end
            end

            if (w_adv) begin
                r_out_valid   <= 1'b1;
                r_out_ctrl    <= ctrl_word;
                r_out_rd      <= r_d_instr[15:11];
                r_out_rs      <= r_d_instr[25:21];
                r_out_rt      <= r_d_instr[20:16];
                r_out_imm     <= w_imm;
                r_out_next_pc <= w_next_pc;
                r_out_data_rs <= data_rs;
                r_out_data_rt <= data_rt;
            end else if (w_bubble) begin
                r_out_valid <= 1'b0;
                r_out_ctrl  <= '0;
            end else if (w_e_free) begin
                r_out_valid <= 1'b0;
            end else begin
                r_out_valid <= r_out_valid;
            end
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_ctrl    = r_out_ctrl;
    assign bus.out_rd      = r_out_rd;
    assign bus.out_rs      = r_out_rs;
    assign bus.out_rt      = r_out_rt;
    assign bus.out_imm     = r_out_imm;
    assign bus.out_next_pc = r_out_next_pc;
    assign bus.out_data_rs = r_out_data_rs;
    assign bus.out_data_rt = r_out_data_rt;

    assign rs         = clamp_addr(r_d_instr[25:21]);
    assign rt         = clamp_addr(r_d_instr[20:16]);
    assign opcode     = r_d_instr[31:26];
    assign funct      = r_d_instr[5:0];
    assign jump_valid = w_jump;
    assign jump_addr  = w_jump_addr;

endmodule

// File: tb/tb_id_stage_hs.sv
// Directed bench for id_stage_hs: one instance without and one with a delay slot, sharing stimulus,
// each with its own small register-file and control-unit model.
module tb_id_stage_hs;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_ready;
    logic        stall;
    logic        flush;
    logic        imm_zext;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    id_stage_hs_if b0 ();
    id_stage_hs_if b1 ();

    assign b0.in_valid  = in_valid;
    assign b0.in_instr  = in_instr;
    assign b0.in_pc     = in_pc;
    assign b0.out_ready = out_ready;
    assign b1.in_valid  = in_valid;
    assign b1.in_instr  = in_instr;
    assign b1.in_pc     = in_pc;
    assign b1.out_ready = out_ready;

    function automatic logic [31:0] rf(input logic [4:0] a);
        return ({27'd0, a} << 8) + 32'h0000_0023;
    endfunction

    function automatic logic [4:0] clampa(input logic [4:0] a);
        return (a < 5'd16) ? a : 5'd15;
    endfunction

    function automatic logic [19:0] cw_of(input logic [31:0] ins);
        return {ins[31:26], ins[5:0], 8'hC3};
    endfunction

    function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] s,
                                         input logic [4:0] t, input logic [15:0] imm);
        return {op, s, t, imm};
    endfunction

    function automatic logic [31:0] mk_j(input logic [5:0] op, input logic [25:0] tgt);
        return {op, tgt};
    endfunction

    logic [4:0]  rs0, rt0, rs1, rt1;
    logic [5:0]  op0, fn0, op1, fn1;
    logic [31:0] ja0, ja1;
    logic        jv0, jv1;

    id_stage_hs #(.DELAY_SLOT(0)) u0 (
        .clk(clk), .rst(rst), .bus(b0.slave), .rs(rs0), .rt(rt0),
        .data_rs(rf(rs0)), .data_rt(rf(rt0) ^ 32'hFFFF_0000), .opcode(op0), .funct(fn0),
        .ctrl_word({op0, fn0, 8'hC3}),
        .is_jump((op0 == 6'd2) || ((op0 == 6'd0) && (fn0 == 6'd8))),
        .sel_j_jr(op0 == 6'd2), .imm_zext(imm_zext), .stall_pipeline(stall), .flush(flush),
        .jump_valid(jv0), .jump_addr(ja0)
    );

    id_stage_hs #(.DELAY_SLOT(1)) u1 (
        .clk(clk), .rst(rst), .bus(b1.slave), .rs(rs1), .rt(rt1),
        .data_rs(rf(rs1)), .data_rt(rf(rt1) ^ 32'hFFFF_0000), .opcode(op1), .funct(fn1),
        .ctrl_word({op1, fn1, 8'hC3}),
        .is_jump((op1 == 6'd2) || ((op1 == 6'd0) && (fn1 == 6'd8))),
        .sel_j_jr(op1 == 6'd2), .imm_zext(imm_zext), .stall_pipeline(stall), .flush(flush),
        .jump_valid(jv1), .jump_addr(ja1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full E-register comparison for instance u0.
    task automatic chk_e0(input string tag, input logic [31:0] ins, input logic [31:0] npc,
                          input logic [31:0] imm);
        check({tag, ".valid"}, b0.out_valid, 1'b1);
        check({tag, ".ctrl"},  b0.out_ctrl, cw_of(ins));
        check({tag, ".npc"},   b0.out_next_pc, npc);
        check({tag, ".rs"},    b0.out_rs, ins[25:21]);
        check({tag, ".rt"},    b0.out_rt, ins[20:16]);
        check({tag, ".rd"},    b0.out_rd, ins[15:11]);
        check({tag, ".imm"},   b0.out_imm, imm);
        check({tag, ".drs"},   b0.out_data_rs, rf(clampa(ins[25:21])));
        check({tag, ".drt"},   b0.out_data_rt, rf(clampa(ins[20:16])) ^ 32'hFFFF_0000);
    endtask

    logic [31:0] ins_a [4];
    logic [31:0] ib, ic, s1, s2, p1, p2, p3, j1, n1, n2, jr, n3, n4, jw;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_instr = 32'd0; in_pc = 32'd0;
        out_ready = 1'b1; stall = 1'b0; flush = 1'b0; imm_zext = 1'b0;

        tick();
        check("rst.in_ready", b0.in_ready, 1'b1);
        check("rst.jump_valid", jv0, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        check("rst.out_valid", b0.out_valid, 1'b0);
        check("rst.out_ctrl", b0.out_ctrl, 20'd0);
        check("rst.out_npc", b0.out_next_pc, 32'd0);
        check("rst.out_imm", b0.out_imm, 32'd0);
        check("rst.out_drs", b0.out_data_rs, 32'd0);
        check("rst.in_ready_after", b0.in_ready, 1'b1);

        // Streaming four instructions back to back.
        for (int i = 0; i < 4; i++) begin
            ins_a[i] = mk_i(6'h08, 5'(i + 1), 5'(i + 2), 16'h0010 + 16'(i));
        end
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_instr = ins_a[i]; in_pc = 32'(i);
            #1;
            check("stream.in_ready", b0.in_ready, 1'b1);
            tick();
            if (i > 0) chk_e0("stream", ins_a[i-1], 32'(i), 32'h0000_0010 + 32'(i - 1));
        end
        in_valid = 1'b0;
        tick();
        chk_e0("stream.last", ins_a[3], 32'd4, 32'h0000_0013);
        tick();
        check("stream.drain", b0.out_valid, 1'b0);

        // Immediate extension and address clamping.
        ib = mk_i(6'h0C, 5'd20, 5'd3, 16'h8001);
        in_valid = 1'b1; in_instr = ib; in_pc = 32'h10; imm_zext = 1'b0;
        tick();
        in_valid = 1'b0;
        #1;
        check("clamp.rs", rs0, 5'd15);
        check("clamp.rt", rt0, 5'd3);
        tick();
        chk_e0("sext", ib, 32'h11, 32'hFFFF_8001);
        ic = mk_i(6'h0D, 5'd5, 5'd31, 16'h8001);
        in_valid = 1'b1; in_instr = ic; in_pc = 32'h11; imm_zext = 1'b1;
        tick();
        in_valid = 1'b0;
        #1;
        check("clamp.rt31", rt0, 5'd15);
        tick();
        chk_e0("zext", ic, 32'h12, 32'h0000_8001);
        imm_zext = 1'b0;

        // Hazard stall with D occupied.
        s1 = mk_i(6'h09, 5'd2, 5'd4, 16'h0021);
        s2 = mk_i(6'h0A, 5'd3, 5'd5, 16'h0022);
        in_valid = 1'b1; in_instr = s1; in_pc = 32'h20;
        tick();
        in_instr = s2; in_pc = 32'h21; stall = 1'b1;
        #1;
        check("stall.in_ready", b0.in_ready, 1'b0);
        for (int k = 0; k < 2; k++) begin
            tick();
            check("stall.bubble_valid", b0.out_valid, 1'b0);
            check("stall.bubble_ctrl", b0.out_ctrl, 20'd0);
            check("stall.d_hold", op0, 6'h09);
            check("stall.in_ready_hold", b0.in_ready, 1'b0);
        end
        stall = 1'b0;
        #1;
        check("stall.release_ready", b0.in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        chk_e0("stall.s1", s1, 32'h21, 32'h0000_0021);
        tick();
        chk_e0("stall.s2", s2, 32'h22, 32'h0000_0022);
        tick();
        check("stall.no_dup", b0.out_valid, 1'b0);

        // Backpressure from EX.
        p1 = mk_i(6'h0B, 5'd6, 5'd7, 16'h0031);
        p2 = mk_i(6'h0E, 5'd7, 5'd8, 16'h0032);
        p3 = mk_i(6'h0F, 5'd8, 5'd9, 16'h0033);
        in_valid = 1'b1; in_instr = p1; in_pc = 32'h30;
        tick();
        in_instr = p2; in_pc = 32'h31;
        tick();
        chk_e0("bp.p1", p1, 32'h31, 32'h0000_0031);
        out_ready = 1'b0; in_instr = p3; in_pc = 32'h32;
        #1;
        check("bp.in_ready", b0.in_ready, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_e0("bp.hold", p1, 32'h31, 32'h0000_0031);
            check("bp.d_hold", op0, 6'h0E);
        end
        out_ready = 1'b1;
        #1;
        check("bp.release_ready", b0.in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        chk_e0("bp.p2", p2, 32'h32, 32'h0000_0032);
        tick();
        chk_e0("bp.p3", p3, 32'h33, 32'h0000_0033);
        tick();
        check("bp.no_dup", b0.out_valid, 1'b0);

        // J with shadow instruction.
        j1 = mk_j(6'h02, 26'h40);
        n1 = mk_i(6'h08, 5'd1, 5'd2, 16'h0041);
        n2 = mk_i(6'h08, 5'd2, 5'd3, 16'h0042);
        in_valid = 1'b1; in_instr = j1; in_pc = 32'h40;
        tick();
        in_instr = n1; in_pc = 32'h41;
        #1;
        check("j.jv0", jv0, 1'b1);
        check("j.ja0", ja0, 32'h40);
        check("j.jv1", jv1, 1'b1);
        check("j.ja1", ja1, 32'h40);
        tick();
        check("j.e_ctrl", b0.out_ctrl, cw_of(j1));
        check("j.e_npc", b0.out_next_pc, 32'h41);
        in_instr = n2; in_pc = 32'h42;
        #1;
        check("j.one_cycle0", jv0, 1'b0);
        check("j.one_cycle1", jv1, 1'b0);
        tick();
        in_valid = 1'b0;
        check("j.squashed", b0.out_valid, 1'b0);
        check("j.ds_valid", b1.out_valid, 1'b1);
        check("j.ds_npc", b1.out_next_pc, 32'h42);
        tick();
        chk_e0("j.after", n2, 32'h43, 32'h0000_0042);

        // JR, squash flag held across an idle cycle.
        jr = {6'd0, 5'd1, 5'd0, 5'd0, 5'd0, 6'd8};
        n3 = mk_i(6'h08, 5'd3, 5'd4, 16'h0051);
        n4 = mk_i(6'h08, 5'd4, 5'd5, 16'h0052);
        in_valid = 1'b1; in_instr = jr; in_pc = 32'h50;
        tick();
        in_valid = 1'b0;
        #1;
        check("jr.jv", jv0, 1'b1);
        check("jr.ja", ja0, 32'h123);
        tick();
        check("jr.e_npc", b0.out_next_pc, 32'h51);
        tick();
        in_valid = 1'b1; in_instr = n3; in_pc = 32'h51;
        tick();
        in_valid = 1'b0;
        tick();
        check("jr.squashed", b0.out_valid, 1'b0);
        check("jr.ds_valid", b1.out_valid, 1'b1);
        check("jr.ds_npc", b1.out_next_pc, 32'h52);
        in_valid = 1'b1; in_instr = n4; in_pc = 32'h52;
        tick();
        in_valid = 1'b0;
        tick();
        chk_e0("jr.after", n4, 32'h53, 32'h0000_0052);

        // Flush colliding with an input accept while E is valid.
        in_valid = 1'b1; in_instr = mk_i(6'h08, 5'd1, 5'd1, 16'h0060); in_pc = 32'h60;
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0; stall = 1'b1;
        #1;
        check("fl1.d_empty", b0.in_ready, 1'b1);
        check("fl1.out_valid", b0.out_valid, 1'b0);
        check("fl1.out_ctrl", b0.out_ctrl, 20'd0);
        stall = 1'b0;

        // Flush colliding with an advance and a new accept.
        in_valid = 1'b1; in_instr = mk_i(6'h10, 5'd1, 5'd2, 16'h0061); in_pc = 32'h61;
        tick();
        in_instr = mk_i(6'h11, 5'd2, 5'd3, 16'h0062); in_pc = 32'h62; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0; stall = 1'b1;
        #1;
        check("fl2.d_empty", b0.in_ready, 1'b1);
        check("fl2.out_valid", b0.out_valid, 1'b0);
        check("fl2.out_ctrl", b0.out_ctrl, 20'd0);
        stall = 1'b0;
        tick();
        check("fl2.nothing_issued", b0.out_valid, 1'b0);

        // Flush clearing a pending squash flag.
        in_valid = 1'b1; in_instr = mk_j(6'h02, 26'h80); in_pc = 32'h70;
        tick();
        in_valid = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl3.out_valid", b0.out_valid, 1'b0);
        jw = mk_i(6'h08, 5'd2, 5'd2, 16'h0071);
        in_valid = 1'b1; in_instr = jw; in_pc = 32'h71;
        tick();
        in_valid = 1'b0;
        tick();
        chk_e0("fl3.next", jw, 32'h72, 32'h0000_0071);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
